// File: rtl/updown_cnt_if.sv
// Button-pulse inputs and counter-control outputs of updown_cnt_ctrl.
// master drives the buttons; slave is the controller.
interface updown_cnt_ctrl_if;
    logic       btn_mode;
    logic       btn_run_stop;
    logic       btn_clear;
    logic       cnt_tick;
    logic       cnt_dir;
    logic       cnt_clr;
    logic [1:0] state;
    logic [3:0] led;

    modport master (
        output btn_mode,
        output btn_run_stop,
        output btn_clear,
        input  cnt_tick,
        input  cnt_dir,
        input  cnt_clr,
        input  state,
        input  led
    );

    modport slave (
        input  btn_mode,
        input  btn_run_stop,
        input  btn_clear,
        output cnt_tick,
        output cnt_dir,
        output cnt_clr,
        output state,
        output led
    );
endinterface

// File: rtl/updown_cnt_ctrl.sv
// Up/down counter controller: STOP/RUN/CLEAR Moore FSM, direction
// register and tick divider that paces the counter datapath.
module updown_cnt_ctrl #(
    parameter int TICK_DIV = 10_000_000
) (
    input  logic              clk,
    input  logic              rst,
    updown_cnt_ctrl_if.slave  bus
);

    localparam int W = $clog2(TICK_DIV);
    localparam logic [W-1:0] LAST = W'(TICK_DIV - 1);

    typedef enum logic [1:0] {
        ST_STOP  = 2'b00,
        ST_RUN   = 2'b01,
        ST_CLEAR = 2'b10
    } state_t;

    state_t         state_q;
    logic           dir_q;
    logic           tick_q;
    logic [W-1:0]   div_cnt;

    // Mode FSM; direction may only flip while stopped, clear wins
    // over run/stop which wins over mode, and losers are dropped.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_STOP;
            dir_q   <= 1'b0;
        end else begin
            case (state_q)
                ST_STOP: begin
                    if (bus.btn_clear)
                        state_q <= ST_CLEAR;
                    else if (bus.btn_run_stop)
                        state_q <= ST_RUN;
                    else if (bus.btn_mode)
                        dir_q <= ~dir_q;
                end
                ST_RUN: begin
                    if (bus.btn_run_stop)
                        state_q <= ST_STOP;
                end
                ST_CLEAR: state_q <= ST_STOP;
                default:  state_q <= ST_STOP;
            endcase
        end
    end

    // Divider runs only in RUN, holds its phase in STOP, zeroed by CLEAR.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_cnt <= '0;
        end else if (state_q == ST_CLEAR) begin
            div_cnt <= '0;
        end else if (state_q == ST_RUN) begin
            if (div_cnt == LAST)
                div_cnt <= '0;
            else
                div_cnt <= div_cnt + W'(1);
        end
    end

    // Tick follows the terminal-count cycle, so a stop on that cycle
    // still delivers the final step.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            tick_q <= 1'b0;
        else
            tick_q <= (state_q == ST_RUN) && (div_cnt == LAST);
    end

    assign bus.state    = state_q;
    assign bus.cnt_dir  = dir_q;
    assign bus.cnt_tick = tick_q;
    assign bus.cnt_clr  = (state_q == ST_CLEAR);
    assign bus.led      = {dir_q, ~dir_q,
                           state_q == ST_RUN,
                           state_q != ST_RUN};

endmodule

// File: tb/tb_updown_cnt_ctrl.sv
// Scoreboard bench for updown_cnt_ctrl with TICK_DIV = 4.
// Expected outputs are queued per driven cycle and checked one edge later.
module tb_updown_cnt_ctrl;

    localparam int TD = 4;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    updown_cnt_ctrl_if bus ();

    updown_cnt_ctrl #(.TICK_DIV(TD)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct packed {
        logic [1:0] st;
        logic       dir;
        logic       tick;
    } exp_t;

    exp_t       sb[$];
    int         tick_log[$];
    logic [1:0] m_st;
    logic       m_dir;
    int         m_div;
    int         checks = 0;
    int         errors = 0;
    int         cyc_n = 0;
    int         win_ticks = 0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_st  = 2'b00;
        m_dir = 1'b0;
        m_div = 0;
        sb.delete();
    endtask

    // Reference behaviour for one clock edge given the sampled buttons.
    task automatic model_step(input logic m, input logic r, input logic c);
        exp_t e;
        logic [1:0] ns;
        logic nd;
        int ndv;
        ns  = m_st;
        nd  = m_dir;
        ndv = m_div;
        e.tick = (m_st == 2'b01) && (m_div == TD - 1);
        case (m_st)
            2'b00: begin
                if (c)      ns = 2'b10;
                else if (r) ns = 2'b01;
                else if (m) nd = ~m_dir;
            end
            2'b01: begin
                if (r) ns = 2'b00;
                ndv = (m_div + 1) % TD;
            end
            2'b10: begin
                ns  = 2'b00;
                ndv = 0;
            end
            default: ns = 2'b00;
        endcase
        m_st  = ns;
        m_dir = nd;
        m_div = ndv;
        e.st  = ns;
        e.dir = nd;
        sb.push_back(e);
    endtask

    task automatic cyc(input logic m, input logic r, input logic c);
        exp_t e;
        bus.btn_mode     = m;
        bus.btn_run_stop = r;
        bus.btn_clear    = c;
        model_step(m, r, c);
        @(negedge clk);
        bus.btn_mode     = 1'b0;
        bus.btn_run_stop = 1'b0;
        bus.btn_clear    = 1'b0;
        cyc_n++;
        e = sb.pop_front();
        chk("state", 32'(bus.state), 32'(e.st));
        chk("dir", 32'(bus.cnt_dir), 32'(e.dir));
        chk("tick", 32'(bus.cnt_tick), 32'(e.tick));
        chk("clr", 32'(bus.cnt_clr), 32'(e.st == 2'b10));
        chk("led", 32'(bus.led),
            32'({e.dir, ~e.dir, e.st == 2'b01, e.st != 2'b01}));
        if (bus.cnt_tick) begin
            tick_log.push_back(cyc_n);
            win_ticks++;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        bus.btn_mode     = 1'b0;
        bus.btn_run_stop = 1'b0;
        bus.btn_clear    = 1'b0;
        rst = 1'b1;
        // Buttons during reset must be ignored.
        @(negedge clk);
        bus.btn_run_stop = 1'b1;
        bus.btn_mode     = 1'b1;
        @(negedge clk);
        bus.btn_run_stop = 1'b0;
        bus.btn_mode     = 1'b0;
        chk("rst_state", 32'(bus.state), 32'd0);
        chk("rst_dir", 32'(bus.cnt_dir), 32'd0);
        chk("rst_tick", 32'(bus.cnt_tick), 32'd0);
        chk("rst_clr", 32'(bus.cnt_clr), 32'd0);
        chk("rst_led", 32'(bus.led), 32'h5);
        rst = 1'b0;
        model_reset();

        // Start run at cycle 0; ticks expected at cycles 5, 9, 13.
        cyc_n = 0;
        tick_log.delete();
        cyc(1'b0, 1'b1, 1'b0);
        chk("run_led", 32'(bus.led), 32'h6);
        idle(13);
        chk("tick_cnt", 32'(tick_log.size()), 32'd3);
        chk("tick_c0", 32'(tick_log[0]), 32'd5);
        chk("tick_c1", 32'(tick_log[1]), 32'd9);
        chk("tick_c2", 32'(tick_log[2]), 32'd13);

        // Stop mid-period, stay quiet, then resume with preserved phase.
        idle(2);
        cyc(1'b0, 1'b1, 1'b0);
        win_ticks = 0;
        idle(20);
        chk("stop_no_tick", 32'(win_ticks), 32'd0);
        cyc(1'b0, 1'b1, 1'b0);
        idle(10);

        // Direction: toggles in STOP, ignored in RUN.
        cyc(1'b0, 1'b1, 1'b0);
        cyc(1'b1, 1'b0, 1'b0);
        chk("dir_set", 32'(bus.cnt_dir), 32'd1);
        chk("dir_led", 32'(bus.led), 32'h9);
        cyc(1'b0, 1'b1, 1'b0);
        cyc(1'b1, 1'b0, 1'b0);
        chk("dir_run_hold", 32'(bus.cnt_dir), 32'd1);
        idle(3);
        cyc(1'b0, 1'b1, 1'b0);

        // All three buttons at once in STOP: clear wins.
        cyc(1'b1, 1'b1, 1'b1);
        chk("clr_state", 32'(bus.state), 32'h2);
        chk("clr_strobe", 32'(bus.cnt_clr), 32'd1);
        idle(1);
        chk("clr_dir_keep", 32'(bus.cnt_dir), 32'd1);
        cyc(1'b0, 1'b1, 1'b0);
        idle(9);

        // Clear and mode ignored while running.
        cyc(1'b1, 1'b0, 1'b1);
        idle(9);

        // Random pulses exercise stop-at-terminal-count and priority.
        for (int i = 0; i < 200; i++)
            cyc($urandom_range(0, 7) == 0,
                $urandom_range(0, 5) == 0,
                $urandom_range(0, 11) == 0);

        // Get into RUN with a tick pending, then reset between edges.
        if (m_st != 2'b01) idle(1);
        if (m_st != 2'b01) cyc(1'b0, 1'b1, 1'b0);
        for (int i = 0; i < TD && m_div != TD - 1; i++) idle(1);
        chk("pre_rst_run", 32'(bus.state), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_state", 32'(bus.state), 32'd0);
        chk("arst_dir", 32'(bus.cnt_dir), 32'd0);
        chk("arst_tick", 32'(bus.cnt_tick), 32'd0);
        chk("arst_led", 32'(bus.led), 32'h5);
        bus.btn_run_stop = 1'b1;
        @(negedge clk);
        bus.btn_run_stop = 1'b0;
        chk("arst_no_tick", 32'(bus.cnt_tick), 32'd0);
        chk("arst_hold", 32'(bus.state), 32'd0);
        rst = 1'b0;
        model_reset();
        cyc_n = 0;
        tick_log.delete();
        cyc(1'b0, 1'b1, 1'b0);
        idle(5);
        chk("post_rst_tick", 32'(tick_log.size()), 32'd1);
        chk("post_rst_c0", 32'(tick_log[0]), 32'd5);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
